mem_port_arbiter: RTL

Shares the single-port text/data memory between the instruction-fetch stage and the load/store unit. Accepts at most one request per cycle and drives the memory's address, write-data, byte-enable and write-enable pins. Registers the memory's asynchronous read data into a one-cycle response for the winning requester. Supports fixed-priority arbitration with starvation relief and a lock mode for read-modify-write sequences.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_grant.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the text/data memory port arbiter.
// Holds the FSM state enum, the grant encoding and the word offset.
package mem_arb_pkg;

   typedef enum logic {
      ARB,
      LOCK
   } state_e;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_IF,
      GNT_LS
   } grant_e;

   // Byte address bits dropped to form the memory word index.
   localparam int WORD_OFS = 2;

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: combinational grant decision for mem_port_arbiter.
// Ports: rst, if/ls request valids, FSM state, starvation counter
// (or last_grant when MEM_ARB_RR_EN is defined) -> grant.
// MEM_ARB_RR_EN selects round-robin instead of fixed priority.
module mem_arb_grant
   import mem_arb_pkg::*;
`ifndef MEM_ARB_RR_EN
#(
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = 3
)
`endif
(
   input  logic             rst,
   input  logic             if_req_valid,
   input  logic             ls_req_valid,
   input  state_e           state,
`ifdef MEM_ARB_RR_EN
   input  grant_e           last_grant,
`else
   input  logic [CNT_W-1:0] wait_cnt,
`endif
   output grant_e           grant
);

   logic if_wins;

`ifdef MEM_ARB_RR_EN
   // The side not served last takes a conflict.
   assign if_wins = (last_grant == GNT_LS);
`else
   // LS normally wins; a starved IF gets one turn.
   assign if_wins = (wait_cnt == CNT_W'(MAX_WAIT));
`endif

   always_comb begin
      grant = GNT_NONE;
      if (!rst) begin
         case (state)
            LOCK: begin
               if (ls_req_valid)
                  grant = GNT_LS;
            end
            default: begin
               if (if_req_valid && ls_req_valid)
                  grant = if_wins ? GNT_IF : GNT_LS;
               else if (if_req_valid)
                  grant = GNT_IF;
               else if (ls_req_valid)
                  grant = GNT_LS;
            end
         endcase
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and LSU.
// Ports: if_* fetch request/response, ls_* load/store request/response,
// mem_* memory pins (async read data on mem_out), clk, sync active-high rst.
// MEM_ARB_RR_EN: round-robin on conflict instead of fixed priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_req_valid,
   output logic                 if_req_ready,
   input  logic [ADDR_W-1:0]    if_addr,
   output logic                 if_rsp_valid,
   output logic [DATA_W-1:0]    if_rdata,
   input  logic                 ls_req_valid,
   output logic                 ls_req_ready,
   input  logic [ADDR_W-1:0]    ls_addr,
   input  logic [DATA_W-1:0]    ls_wdata,
   input  logic [3:0]           ls_byteen,
   input  logic                 ls_we,
   input  logic                 ls_lock,
   output logic                 ls_rsp_valid,
   output logic [DATA_W-1:0]    ls_rdata,
   output logic [ADDR_W-3:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_in,
   output logic [3:0]           mem_byteen,
   output logic                 mem_we,
   input  logic [DATA_W-1:0]    mem_out
);

   localparam int AW = ADDR_W - WORD_OFS;

   state_e            state_q;
   grant_e            grant;
   logic [AW-1:0]     addr_q;
   logic [AW-1:0]     req_addr;
   logic              if_rsp_q;
   logic              ls_rsp_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] ls_rdata_q;
   logic              unused_addr_lsb;

   assign unused_addr_lsb = ^{if_addr[WORD_OFS-1:0],
                              ls_addr[WORD_OFS-1:0]};

`ifdef MEM_ARB_RR_EN
   grant_e last_q;
   grant_e last_d;

   mem_arb_grant u_grant (
      .rst          (rst),
      .if_req_valid (if_req_valid),
      .ls_req_valid (ls_req_valid),
      .state        (state_q),
      .last_grant   (last_q),
      .grant        (grant)
   );

   always_comb begin
      last_d = last_q;
      if (grant != GNT_NONE)
         last_d = grant;
   end
`else
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] wait_q;
   logic [CNT_W-1:0] wait_d;

   mem_arb_grant #(
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
   ) u_grant (
      .rst          (rst),
      .if_req_valid (if_req_valid),
      .ls_req_valid (ls_req_valid),
      .state        (state_q),
      .wait_cnt     (wait_q),
      .grant        (grant)
   );

   // Counts only denials in ARB; LOCK denials leave it untouched.
   always_comb begin
      wait_d = wait_q;
      if (!if_req_valid || if_req_ready)
         wait_d = '0;
      else if (state_q == ARB && wait_q != CNT_W'(MAX_WAIT))
         wait_d = wait_q + 1'b1;
   end
`endif

   assign if_req_ready = (grant == GNT_IF);
   assign ls_req_ready = (grant == GNT_LS);

   assign req_addr = ls_req_ready ? ls_addr[ADDR_W-1:WORD_OFS]
                                  : if_addr[ADDR_W-1:WORD_OFS];

   // Address is parked on the last granted word when idle.
   assign mem_addr   = (grant != GNT_NONE) ? req_addr : addr_q;
   assign mem_in     = ls_wdata;
   assign mem_we     = ls_req_ready & ls_we;
   assign mem_byteen = ls_req_ready ? ls_byteen : 4'b0000;

   // A reset arriving in the response cycle hides the pending pulse.
   assign if_rsp_valid = if_rsp_q & ~rst;
   assign ls_rsp_valid = ls_rsp_q & ~rst;
   assign if_rdata     = if_rdata_q;
   assign ls_rdata     = ls_rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB;
         addr_q     <= '0;
         if_rsp_q   <= 1'b0;
         ls_rsp_q   <= 1'b0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
         last_q     <= GNT_IF;
`else
         wait_q     <= '0;
`endif
      end else begin
         case (state_q)
            ARB: if (ls_req_ready && ls_lock) state_q <= LOCK;
            LOCK: if (ls_req_ready && !ls_lock) state_q <= ARB;
            default: state_q <= ARB;
         endcase
         addr_q   <= mem_addr;
         if_rsp_q <= if_req_ready;
         ls_rsp_q <= ls_req_ready;
         if (if_req_ready)
            if_rdata_q <= mem_out;
         if (ls_req_ready)
            ls_rdata_q <= mem_out;
`ifdef MEM_ARB_RR_EN
         last_q   <= last_d;
`else
         wait_q   <= wait_d;
`endif
      end
   end

endmodule
